f_regfile_sb: RTL

Parametrised floating-point register file with an integrated busy-bit scoreboard. It replaces the fixed 32x32, 2-read/1-write FP register file in the FPU issue stage. It provides:
- N combinational read ports, so R4-type fused ops (fmadd etc.) can read rs3.
- Two write ports: a short-latency load/move path and a long-latency FPU result path.
- Same-cycle write-to-read bypass.
- Per-register pending bits, which the issue logic uses to stall on RAW/WAW hazards against in-flight FPU operations.

---
 rtl/f_regfile_sb.sv | 76 +++++++
 1 files changed

// File: rtl/f_regfile_sb.sv
// f_regfile_sb: FP register file with N read ports, two write ports, same-cycle bypass and a busy-bit scoreboard.
// Optional F_REGFILE_ZERO_REG0_EN hardwires index 0 to zero for reuse as the integer file.
module f_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 3,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*IDX_W-1:0]  rd_idx,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [IDX_W-1:0]         wa_idx,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [IDX_W-1:0]         wb_idx,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     iss_en,
  input  logic [IDX_W-1:0]         iss_idx,
  input  logic                     flush,
  output logic                     any_pending,
  output logic                     wr_conflict
);
`ifdef F_REGFILE_ZERO_REG0_EN
  localparam bit ZERO0 = 1'b1;
`else
  localparam bit ZERO0 = 1'b0;
`endif
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              wr_conflict_q, wr_conflict_d;
  logic              wa_ok, wb_ok, iss_ok;
  // Out-of-range indices and a hardwired index 0 behave as a constant-zero, never-busy register.
  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < (IDX_W+1)'(DEPTH)) && !(ZERO0 && idx == '0);
  endfunction
  assign wa_ok         = wa_en && idx_ok(wa_idx);
  assign wb_ok         = wb_en && idx_ok(wb_idx);
  assign iss_ok        = iss_en && idx_ok(iss_idx);
  assign wr_conflict_d = wa_ok && wb_ok && wa_idx == wb_idx;
  assign wr_conflict   = wr_conflict_q;
  assign any_pending   = |pend_q;
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [IDX_W-1:0] r;
    assign r = rd_idx[g*IDX_W +: IDX_W];
    assign rd_data[g*DATA_W +: DATA_W] = !idx_ok(r) ? '0 :
                                         (wa_ok && wa_idx == r) ? wa_data :
                                         (wb_ok && wb_idx == r) ? wb_data : mem_q[r];
    assign rd_busy[g] = idx_ok(r) && pend_q[r] && !(wb_ok && wb_idx == r);
  end
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    for (int k = 0; k < DEPTH; k++) begin
      mem_d[k]  = (wa_ok && wa_idx == IDX_W'(k)) ? wa_data :
                  (wb_ok && wb_idx == IDX_W'(k)) ? wb_data : mem_q[k];
      pend_d[k] = flush ? 1'b0 :
                  (iss_ok && iss_idx == IDX_W'(k)) ? 1'b1 :
                  (wb_ok && wb_idx == IDX_W'(k)) ? 1'b0 : pend_q[k];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      pend_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      pend_q        <= pend_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end
endmodule
